// File: rtl/safe_pkg.sv
// Shared definitions for the safe lock controller: keypad codes, FSM state
// encoding and the entry-buffer operation selector.
package safe_pkg;

    // Keypad function codes; 0-9 are digits, F is ignored everywhere
    localparam logic [3:0] KEY_CLR  = 4'hA;
    localparam logic [3:0] KEY_BS   = 4'hB;
    localparam logic [3:0] KEY_LOCK = 4'hC;
    localparam logic [3:0] KEY_CHG  = 4'hD;
    localparam logic [3:0] KEY_ENT  = 4'hE;

    typedef enum logic [2:0] {
        ST_ENTRY  = 3'd0,
        ST_CHECK  = 3'd1,
        ST_OPEN   = 3'd2,
        ST_SET_PW = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    // What the entry buffer does on the next edge
    typedef enum logic [1:0] {
        BUF_HOLD,
        BUF_PUSH,
        BUF_POP,
        BUF_CLR
    } buf_op_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/safe_timer.sv
// 32-bit loadable down-counter. A load starts a run of load_val cycles;
// expired pulses high for the last cycle of the run so the consumer acts
// on the edge that completes it. clear abandons a run in progress.
module safe_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_val,
    output logic        expired
);

    logic [31:0] cnt_q;
    logic        run_q;

    assign expired = run_q && (cnt_q == 32'd1);

    // Count down while running; a new load always wins over clear/count
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (load) begin
            cnt_q <= load_val;
            run_q <= (load_val != 32'd0);
        end else if (clear) begin
            run_q <= 1'b0;
        end else if (run_q) begin
            cnt_q <= cnt_q - 32'd1;
            if (cnt_q == 32'd1) run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/safe_lock_ctrl.sv
// Keypad-driven safe controller: entry buffer, password check, failure
// counting with lockout, and password change. Optional auto-relock of an
// open safe after an idle period is built when SAFE_AUTO_RELOCK_EN is defined.
module safe_lock_ctrl
    import safe_pkg::*;
#(
    parameter logic [15:0] DEFAULT_PW     = 16'h1234,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 500_000_000,
    parameter int unsigned RELOCK_CYCLES  = 1_500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] p0,
    output logic [3:0] p1,
    output logic [3:0] p2,
    output logic [3:0] p3,
    output logic [3:0] digit_valid,
    output logic       show_digits,
    output logic       unlocked,
    output logic       alarm,
    output logic [2:0] state_o
);

    localparam logic [2:0] MAX_T = 3'(MAX_TRIES);

    state_t            state_q, state_d;
    logic [3:0][3:0]   pbuf;
    logic [3:0]        dv_q;
    logic [2:0]        count_q;
    logic [2:0]        fail_cnt;
    logic [15:0]       stored_pw;

    buf_op_t           buf_key_op, buf_op;
    logic              pw_write, fail_clr, fail_inc;
    logic              tmr_load, tmr_clear, tmr_exp;
    logic [31:0]       tmr_val;
    logic              pw_match;
    logic [2:0]        fail_next;
    logic              show_d, unl_d, alarm_d;

    assign p0          = pbuf[0];
    assign p1          = pbuf[1];
    assign p2          = pbuf[2];
    assign p3          = pbuf[3];
    assign digit_valid = dv_q;
    assign state_o     = state_q;

    assign pw_match  = ({pbuf[0], pbuf[1], pbuf[2], pbuf[3]} == stored_pw);
    assign fail_next = (fail_cnt >= MAX_T) ? MAX_T : fail_cnt + 3'd1;

    safe_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .clear    (tmr_clear),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

`ifndef SAFE_AUTO_RELOCK_EN
    // Relock period is only meaningful with auto-relock built in
    logic [31:0] unused_relock_cfg;
    assign unused_relock_cfg = 32'(RELOCK_CYCLES);
`endif

    // Buffer edit requested by the current key (used in ENTRY and SET_PW)
    always_comb begin
        buf_key_op = BUF_HOLD;
        if (key_valid) begin
            if (is_digit(key_code) && count_q != 3'd4) buf_key_op = BUF_PUSH;
            else if (key_code == KEY_BS && count_q != 3'd0) buf_key_op = BUF_POP;
            else if (key_code == KEY_CLR) buf_key_op = BUF_CLR;
        end
    end

    // Next-state, buffer, password, failure and timer control
    always_comb begin
        state_d   = state_q;
        buf_op    = BUF_HOLD;
        pw_write  = 1'b0;
        fail_clr  = 1'b0;
        fail_inc  = 1'b0;
        tmr_load  = 1'b0;
        tmr_clear = 1'b0;
        tmr_val   = 32'(LOCKOUT_CYCLES);
        case (state_q)
            ST_ENTRY: begin
                buf_op = buf_key_op;
                if (key_valid && key_code == KEY_ENT && count_q == 3'd4)
                    state_d = ST_CHECK;
            end
            ST_CHECK: begin
                buf_op = BUF_CLR;
                if (pw_match) begin
                    state_d  = ST_OPEN;
                    fail_clr = 1'b1;
                end else begin
                    fail_inc = 1'b1;
                    if (fail_next == MAX_T) begin
                        state_d  = ST_LOCKED;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = ST_ENTRY;
                    end
                end
            end
            ST_LOCKED: begin
                if (tmr_exp) begin
                    state_d  = ST_ENTRY;
                    fail_clr = 1'b1;
                end
            end
            ST_OPEN: begin
`ifdef SAFE_AUTO_RELOCK_EN
                // Idle expiry beats any key on the same edge
                if (tmr_exp) state_d = ST_ENTRY;
                else
`endif
                if (key_valid && key_code == KEY_LOCK) begin
                    state_d = ST_ENTRY;
                end else if (key_valid && key_code == KEY_CHG) begin
                    state_d = ST_SET_PW;
                    buf_op  = BUF_CLR;
                end
            end
            ST_SET_PW: begin
                buf_op = buf_key_op;
                if (key_valid && key_code == KEY_ENT && count_q == 3'd4) begin
                    pw_write = 1'b1;
                    buf_op   = BUF_CLR;
                    state_d  = ST_OPEN;
                end else if (key_valid && key_code == KEY_LOCK) begin
                    buf_op  = BUF_CLR;
                    state_d = ST_OPEN;
                end
            end
            default: state_d = ST_ENTRY;
        endcase
`ifdef SAFE_AUTO_RELOCK_EN
        // Idle timer restarts on entry to OPEN and on every key while open
        if (state_d == ST_OPEN && (state_q != ST_OPEN || key_valid)) begin
            tmr_load = 1'b1;
            tmr_val  = 32'(RELOCK_CYCLES);
        end else if (state_q == ST_OPEN && state_d != ST_OPEN) begin
            tmr_clear = 1'b1;
        end
`endif
    end

    // Output decode from the next state so the outputs can be registered
    always_comb begin
        show_d  = (state_d == ST_SET_PW);
        unl_d   = (state_d == ST_OPEN) || (state_d == ST_SET_PW);
        alarm_d = (state_d == ST_LOCKED);
    end

    // State and status output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ENTRY;
            show_digits <= 1'b0;
            unlocked    <= 1'b0;
            alarm       <= 1'b0;
        end else begin
            state_q     <= state_d;
            show_digits <= show_d;
            unlocked    <= unl_d;
            alarm       <= alarm_d;
        end
    end

    // Entry buffer: digits fill from position 0, backspace clears the top one
    always_ff @(posedge clk) begin
        if (rst) begin
            pbuf    <= '0;
            dv_q    <= '0;
            count_q <= '0;
        end else begin
            case (buf_op)
                BUF_PUSH: begin
                    pbuf[count_q[1:0]] <= key_code;
                    dv_q[count_q[1:0]] <= 1'b1;
                    count_q            <= count_q + 3'd1;
                end
                BUF_POP: begin
                    pbuf[2'(count_q - 3'd1)] <= 4'd0;
                    dv_q[2'(count_q - 3'd1)] <= 1'b0;
                    count_q                  <= count_q - 3'd1;
                end
                BUF_CLR: begin
                    pbuf    <= '0;
                    dv_q    <= '0;
                    count_q <= '0;
                end
                default: ;
            endcase
        end
    end

    // Stored password and saturating failure counter
    always_ff @(posedge clk) begin
        if (rst) begin
            stored_pw <= DEFAULT_PW;
            fail_cnt  <= '0;
        end else begin
            if (pw_write) stored_pw <= {pbuf[0], pbuf[1], pbuf[2], pbuf[3]};
            if (fail_clr) fail_cnt <= '0;
            else if (fail_inc) fail_cnt <= fail_next;
        end
    end

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Self-checking bench for safe_lock_ctrl: directed scenarios plus randomized
// key traffic, compared every cycle against a queue-based behavioural model.
module tb_safe_lock_ctrl;

    localparam int LOCK_N   = 20;
    localparam int RELOCK_N = 30;
    localparam int MAXT     = 3;

    localparam int M_ENTRY = 0, M_CHECK = 1, M_OPEN = 2, M_SET = 3, M_LOCK = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic [3:0] p0, p1, p2, p3, digit_valid;
    logic       show_digits, unlocked, alarm;
    logic [2:0] state_o;

    safe_lock_ctrl #(
        .DEFAULT_PW     (16'h1234),
        .MAX_TRIES      (MAXT),
        .LOCKOUT_CYCLES (LOCK_N),
        .RELOCK_CYCLES  (RELOCK_N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .p0          (p0),
        .p1          (p1),
        .p2          (p2),
        .p3          (p3),
        .digit_valid (digit_valid),
        .show_digits (show_digits),
        .unlocked    (unlocked),
        .alarm       (alarm),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: typed digits as a queue, password as a digit array,
    // remaining cycles of the active wait as a plain integer.
    int m_q[$];
    int m_pw[4];
    int m_fails;
    int m_mode;
    int m_left;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_pw = '{1, 2, 3, 4};
        m_fails = 0;
        m_mode = M_ENTRY;
        m_left = 0;
    endfunction

    function automatic void buf_key(input int k);
        if (k <= 9) begin
            if (m_q.size() < 4) m_q.push_back(k);
        end else if (k == 11) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
        end else if (k == 10) begin
            m_q.delete();
        end
    endfunction

    function automatic void model_step(input bit kv, input int k);
        bit match;
        case (m_mode)
            M_ENTRY: if (kv) begin
                buf_key(k);
                if (k == 14 && m_q.size() == 4) m_mode = M_CHECK;
            end
            M_CHECK: begin
                match = 1;
                for (int i = 0; i < 4; i++) if (m_q[i] != m_pw[i]) match = 0;
                m_q.delete();
                if (match) begin
                    m_mode = M_OPEN; m_fails = 0; m_left = RELOCK_N;
                end else begin
                    if (m_fails < MAXT) m_fails++;
                    if (m_fails == MAXT) begin m_mode = M_LOCK; m_left = LOCK_N; end
                    else m_mode = M_ENTRY;
                end
            end
            M_LOCK: begin
                m_left--;
                if (m_left == 0) begin m_mode = M_ENTRY; m_fails = 0; end
            end
            M_OPEN: begin
`ifdef SAFE_AUTO_RELOCK_EN
                m_left--;
                if (m_left == 0) begin m_mode = M_ENTRY; return; end
                if (kv) m_left = RELOCK_N;
`endif
                if (kv && k == 12) m_mode = M_ENTRY;
                else if (kv && k == 13) begin m_mode = M_SET; m_q.delete(); end
            end
            M_SET: if (kv) begin
                buf_key(k);
                if (k == 14 && m_q.size() == 4) begin
                    for (int i = 0; i < 4; i++) m_pw[i] = m_q[i];
                    m_q.delete(); m_mode = M_OPEN; m_left = RELOCK_N;
                end else if (k == 12) begin
                    m_q.delete(); m_mode = M_OPEN; m_left = RELOCK_N;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [25:0] model_out();
        logic [3:0] d[4];
        logic [3:0] dv;
        dv = 4'd0;
        for (int i = 0; i < 4; i++) begin
            d[i] = (i < m_q.size()) ? 4'(m_q[i]) : 4'd0;
            dv[i] = (i < m_q.size());
        end
        return {d[0], d[1], d[2], d[3], dv, 1'(m_mode == M_SET),
                1'(m_mode == M_OPEN || m_mode == M_SET), 1'(m_mode == M_LOCK), 3'(m_mode)};
    endfunction

    task automatic cyc(input bit kv, input logic [3:0] kc, input bit r = 1'b0);
        rst = r; key_valid = kv; key_code = kc;
        @(posedge clk);
        if (r) model_reset(); else model_step(kv, int'(kc));
        #1;
        chk("outs", {6'd0, p0, p1, p2, p3, digit_valid, show_digits, unlocked, alarm, state_o},
            {6'd0, model_out()});
        rst = 1'b0; key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'd0);
    endtask

    task automatic keys(input string s);
        int k;
        for (int i = 0; i < s.len(); i++) begin
            k = (s[i] >= "0" && s[i] <= "9") ? int'(s[i] - "0") : int'(s[i] - "A") + 10;
            cyc(1'b1, 4'(k));
        end
    endtask

    initial begin
        model_reset();
        #1;
        cyc(1'b0, 4'd0, 1'b1);
        cyc(1'b0, 4'd0, 1'b1);
        chk("reset_state", {29'd0, state_o}, 32'd0);
        chk("reset_flags", {28'd0, show_digits, unlocked, alarm, 1'b0}, 32'd0);

        // Correct code: one CHECK cycle, then open with an empty buffer
        keys("1234E");
        chk("check_state", {29'd0, state_o}, 32'd1);
        idle(1);
        chk("open_state", {29'd0, state_o}, 32'd2);
        chk("open_unl", {31'd0, unlocked}, 32'd1);
        chk("open_dv", {28'd0, digit_valid}, 32'd0);
        keys("C");

        // Backspace removes the top digit
        keys("129B");
        chk("bs_dv", {28'd0, digit_valid}, 32'h3);
        chk("bs_p2", {28'd0, p2}, 32'd0);
        keys("34E"); idle(1);
        chk("bs_open", {31'd0, unlocked}, 32'd1);
        keys("C");

        // Short entry ignored, then three failures lock out
        keys("12E");
        chk("short_ent", {29'd0, state_o}, 32'd0);
        keys("A");
        for (int t = 0; t < 3; t++) begin keys("0000E"); idle(1); end
        chk("locked_alarm", {31'd0, alarm}, 32'd1);
        keys("1234E");
        idle(14);
        chk("still_locked", {29'd0, state_o}, 32'd4);
        idle(1);
        chk("lock_expire", {29'd0, state_o}, 32'd0);
        chk("lock_alarm0", {31'd0, alarm}, 32'd0);

        // Password change, then the old code fails and the new one opens
        keys("1234E"); idle(1);
        keys("D5678");
        chk("setpw_show", {31'd0, show_digits}, 32'd1);
        keys("E");
        chk("setpw_back", {29'd0, state_o}, 32'd2);
        keys("C1234E"); idle(1);
        chk("old_pw_fail", {31'd0, unlocked}, 32'd0);
        keys("5678E"); idle(1);
        chk("new_pw_open", {31'd0, unlocked}, 32'd1);

        // Aborted change keeps the password; reset mid-change restores default
        cyc(1'b0, 4'd0, 1'b1);
        keys("1234E"); idle(1);
        keys("D56C");
        chk("abort_open", {29'd0, state_o}, 32'd2);
        keys("C1234E"); idle(1);
        chk("abort_keep", {31'd0, unlocked}, 32'd1);
        keys("D99");
        cyc(1'b0, 4'd0, 1'b1);
        chk("rst_midchg", {29'd0, state_o}, 32'd0);
        keys("1234E"); idle(1);
        chk("rst_default", {31'd0, unlocked}, 32'd1);
        keys("C");

`ifdef SAFE_AUTO_RELOCK_EN
        keys("1234E"); idle(1);
        idle(RELOCK_N - 1);
        chk("relock_pre", {31'd0, unlocked}, 32'd1);
        idle(1);
        chk("relock_st", {29'd0, state_o}, 32'd0);
        keys("1234E"); idle(1);
        idle(19);
        cyc(1'b1, 4'hF);
        idle(RELOCK_N - 1);
        chk("relock_delay", {31'd0, unlocked}, 32'd1);
        idle(1);
        chk("relock_late", {31'd0, unlocked}, 32'd0);
`endif

        // Randomized traffic
        for (int r = 0; r < 60; r++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 3) begin
                keys($sformatf("%0d%0d%0d%0dE", m_pw[0], m_pw[1], m_pw[2], m_pw[3]));
                idle(1);
            end else if (sel == 3) begin
                cyc(1'b0, 4'd0, 1'b1);
            end else if (sel == 4) begin
                keys($sformatf("D%0d%0d%0d%0dE", $urandom_range(0, 9), $urandom_range(0, 9),
                               $urandom_range(0, 9), $urandom_range(0, 9)));
            end else begin
                int n;
                n = $urandom_range(1, 12);
                for (int i = 0; i < n; i++) begin
                    cyc(1'b1, 4'($urandom_range(0, 15)));
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
            end
        end
        idle(LOCK_N + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
